// File: rtl/aes_buf_seq_pkg.sv
// -----------------------------------------------------------------------------
// aes_buf_seq_pkg
// Shared definitions for the custom-buffer AES sequencer: key-size encodings,
// sequencer FSM states, staging-buffer index constants and the write-pointer
// advance helper.
// -----------------------------------------------------------------------------
package aes_buf_seq_pkg;

    // Key-size encodings as carried by the AES_W instruction.
    typedef enum logic [1:0] {
        KS_128 = 2'd0,
        KS_192 = 2'd1,
        KS_256 = 2'd2,
        KS_BAD = 2'd3
    } key_size_e;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    // Staging-buffer layout: words 0-3 plaintext block, words 4-11 key.
    localparam int BLK_BASE = 0;
    localparam int KEY_BASE = 4;
    localparam int LAST_IDX = 11;
    localparam int PTR_W    = 4;

    // Advance the write pointer with wrap after the last word. Any pointer
    // value beyond the last word also returns to 0 so a corrupted pointer
    // recovers instead of addressing a non-existent word forever.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr >= PTR_W'(LAST_IDX)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + {{(PTR_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/aes_buf_regfile.sv
// -----------------------------------------------------------------------------
// aes_buf_regfile
// 12-word staging buffer with its write pointer. Words 0-3 form the plaintext
// block, words 4-11 the key; both are presented flattened, word 0 of each
// group in the least-significant position.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (pointer and all words to 0)
//   wr_en   in   write wdata into the word addressed by the pointer
//   inc_en  in   advance the pointer (wraps 11 -> 0); a simultaneous write
//                uses the old pointer
//   wdata   in   write data
//   block   out  {buf[3],buf[2],buf[1],buf[0]}
//   key     out  {buf[11],...,buf[4]}
// -----------------------------------------------------------------------------
module aes_buf_regfile
    import aes_buf_seq_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BUF_WORDS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                inc_en,
    input  logic [DATA_W-1:0]   wdata,
    output logic [4*DATA_W-1:0] block,
    output logic [8*DATA_W-1:0] key
);

    logic [DATA_W-1:0] buf_r [BUF_WORDS];
    logic [PTR_W-1:0]  wr_ptr_r;

    // Write pointer with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (inc_en) begin
            wr_ptr_r <= ptr_next(wr_ptr_r);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Buffer words; the write always targets the pre-increment pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BUF_WORDS; i++) begin
            if (rst) begin
                buf_r[i] <= {DATA_W{1'b0}};
            end else if (wr_en && (wr_ptr_r == PTR_W'(i))) begin
                buf_r[i] <= wdata;
            end else begin
                buf_r[i] <= buf_r[i];
            end
        end
    end

    // Flatten the block and key groups for the core.
    always_comb begin
        block = {(4*DATA_W){1'b0}};
        key   = {(8*DATA_W){1'b0}};
        for (int i = 0; i < 4; i++) begin
            block[i*DATA_W +: DATA_W] = buf_r[BLK_BASE + i];
        end
        for (int i = 0; i < 8; i++) begin
            key[i*DATA_W +: DATA_W] = buf_r[KEY_BASE + i];
        end
    end

endmodule

// File: rtl/aes_buf_seq.sv
// -----------------------------------------------------------------------------
// aes_buf_seq
// Sequencer between the custom-buffer instructions (load_temp, plus1, AES_W,
// enable_AES) and the AES core. Owns the staging buffer, the latched key size,
// the start/done handshake, the pipeline stall and the 128-bit result register.
//
// Optional feature macro: AES_BUF_SEQ_TIMEOUT_EN
//   defined   -> watchdog aborts a run with no aes_done (err set, back to IDLE)
//   undefined -> the sequencer waits for aes_done indefinitely
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   load_temp          write wdata into buf[wr_ptr]        (IDLE only)
//   plus1              advance wr_ptr                      (IDLE only)
//   aes_w              latch key_size_in                   (IDLE only)
//   key_size_in        0=128, 1=192, 2=256, 3=illegal
//   enable_aes         request an AES run
//   wdata              write data (rs1 operand)
//   stall              hold the issuing instruction while a run is active
//   aes_start          one-cycle launch pulse to the core
//   aes_key_size       latched key size
//   aes_block          staging words 3..0
//   aes_key            staging words 11..4
//   aes_done           core completion pulse
//   aes_result         core output, valid with aes_done
//   result_valid       result register holds a fresh result
//   rd_sel / rd_data   result word select / combinational read-back (0 = LSW)
//   err                sticky error (illegal key size or watchdog expiry)
// -----------------------------------------------------------------------------
module aes_buf_seq
    import aes_buf_seq_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int BUF_WORDS   = 12,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_temp,
    input  logic              plus1,
    input  logic              aes_w,
    input  logic [1:0]        key_size_in,
    input  logic              enable_aes,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              aes_start,
    output logic [1:0]        aes_key_size,
    output logic [127:0]      aes_block,
    output logic [255:0]      aes_key,
    input  logic              aes_done,
    input  logic [127:0]      aes_result,
    output logic              result_valid,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              err
);

    seq_state_e   state_r;
    seq_state_e   state_s;
    logic         idle_s;
    logic         launch_s;
    logic         capture_s;
    logic         bad_ks_s;
    logic         timeout_s;
    logic [1:0]   key_size_r;
    logic [127:0] result_r;
    logic         result_valid_r;
    logic         aes_start_r;
    logic         err_r;

    assign idle_s = (state_r == ST_IDLE);

    // Any custom strobe outside IDLE is held off until the run completes.
    assign stall = (!idle_s) & (load_temp | plus1 | aes_w | enable_aes);

    aes_buf_regfile #(
        .DATA_W    (DATA_W),
        .BUF_WORDS (BUF_WORDS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (load_temp & idle_s),
        .inc_en (plus1 & idle_s),
        .wdata  (wdata),
        .block  (aes_block),
        .key    (aes_key)
    );

`ifdef AES_BUF_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] wd_cnt_r;
    logic [WD_W-1:0] wd_nxt_s;
    logic            wd_expire_s;

    assign wd_nxt_s    = wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
    // Expiry fires on the WAIT cycle whose increment reaches the limit.
    assign wd_expire_s = (wd_nxt_s == WD_W'(TIMEOUT_CYC - 1));

    // Watchdog: cleared when a run is launched, counts each WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (launch_s) begin
            wd_cnt_r <= {WD_W{1'b0}};
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_nxt_s;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state and per-cycle event decode.
    always_comb begin
        state_s   = state_r;
        launch_s  = 1'b0;
        capture_s = 1'b0;
        bad_ks_s  = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_aes) begin
                    if (key_size_r == KS_BAD) begin
                        bad_ks_s = 1'b1;
                        state_s  = ST_IDLE;
                    end else begin
                        launch_s = 1'b1;
                        state_s  = ST_START;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // A core that finishes immediately is honoured here too.
                if (aes_done) begin
                    capture_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (aes_done) begin
                    capture_s = 1'b1;
                    state_s   = ST_IDLE;
`ifdef AES_BUF_SEQ_TIMEOUT_EN
                end else if (wd_expire_s) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Launch pulse registered so it is high exactly during START.
    always_ff @(posedge clk) begin
        if (rst) begin
            aes_start_r <= 1'b0;
        end else begin
            aes_start_r <= launch_s;
        end
    end

    // Key size latch, frozen while a run is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_size_r <= 2'd0;
        end else if (aes_w && idle_s) begin
            key_size_r <= key_size_in;
        end else begin
            key_size_r <= key_size_r;
        end
    end

    // Result register and freshness flag (cleared when a new run starts).
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r       <= 128'd0;
            result_valid_r <= 1'b0;
        end else if (capture_s) begin
            result_r       <= aes_result;
            result_valid_r <= 1'b1;
        end else if (launch_s) begin
            result_r       <= result_r;
            result_valid_r <= 1'b0;
        end else begin
            result_r       <= result_r;
            result_valid_r <= result_valid_r;
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (bad_ks_s || timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    // Result word read-back, word 0 is the least-significant word.
    always_comb begin
        rd_data = {DATA_W{1'b0}};
        case (rd_sel)
            2'd0:    rd_data = result_r[31:0];
            2'd1:    rd_data = result_r[63:32];
            2'd2:    rd_data = result_r[95:64];
            2'd3:    rd_data = result_r[127:96];
            default: rd_data = {DATA_W{1'b0}};
        endcase
    end

    assign aes_start    = aes_start_r;
    assign aes_key_size = key_size_r;
    assign result_valid = result_valid_r;
    assign err          = err_r;

endmodule

// File: doc/aes_buf_seq.md
Name: aes_buf_seq

Overview:
Sequencer between the decoded custom-buffer instructions (opcode 0101011: load_temp, plus1, AES_W, enable_AES) and the AES core.
- Owns a 12-word staging buffer: words 0-3 hold the plaintext block, words 4-11 hold the key.
- Owns the buffer write pointer and the latched key size.
- Launches the AES core with a start/done handshake, stalls the pipeline while busy, and captures the 128-bit result for read-back.

Parameters:
DATA_W, 32, width of one buffer word and of the write data
BUF_WORDS, 12, staging buffer depth (4 block words + 8 key words)
TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with AES_BUF_SEQ_TIMEOUT_EN

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
load_temp  in  1  write wdata into buf[wr_ptr]
plus1  in  1  advance wr_ptr
aes_w  in  1  latch key_size_in
key_size_in  in  2  0=128, 1=192, 2=256, 3=illegal
enable_aes  in  1  request an AES run
wdata  in  DATA_W  rs1 operand
stall  out  1  hold the issuing instruction
aes_start  out  1  one-cycle launch pulse to the core
aes_key_size  out  2  latched key size
aes_block  out  128  {buf[3],buf[2],buf[1],buf[0]}
aes_key  out  256  {buf[11],...,buf[4]}
aes_done  in  1  core completion pulse
aes_result  in  128  core output, valid with aes_done
result_valid  out  1  result register holds a fresh result
rd_sel  in  2  result word select
rd_data  out  DATA_W  result word rd_sel (combinational)
err  out  1  sticky error flag

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, wr_ptr=0, key_size reg=0, all buffer words=0, result reg=0, result_valid=0, err=0, aes_start=0.
- Buffer writes (IDLE only):
  - load_temp: buf[wr_ptr] <= wdata, visible on aes_block/aes_key the next cycle.
  - plus1: wr_ptr <= wr_ptr+1; wraps from 11 to 0.
  - load_temp and plus1 in the same cycle: write at the old pointer, then increment.
  - aes_w: key_size reg <= key_size_in.
- FSM states:
  - IDLE:
    - enable_aes with key_size≠3 -> START, and result_valid is cleared.
    - enable_aes with key_size=3 -> err<=1, stay in IDLE, no start.
  - START: aes_start=1 for exactly this cycle -> WAIT. An aes_done seen in START is accepted as in WAIT.
  - WAIT: on aes_done, result <= aes_result, result_valid <= 1, -> IDLE.
- stall = (state≠IDLE) & (load_temp|plus1|aes_w|enable_aes).
  - Custom strobes arriving while not IDLE have no effect; the held instruction re-presents its strobe once IDLE is reached.
  - enable_aes itself does not stall in the cycle it is accepted.
- Buffer, pointer and key size are frozen outside IDLE, so aes_block, aes_key and aes_key_size stay stable for the whole run.
- rd_data = result[32*rd_sel +: 32]; word 0 is the LSW.
- aes_done while IDLE is ignored.
- rst during START/WAIT: return to IDLE with all reset values; a later late aes_done is ignored.
- err clears only on reset.

Optional Feature:
AES_BUF_SEQ_TIMEOUT_EN
- Defined: a watchdog counter (clog2(TIMEOUT_CYC)+1 bits) clears on entry to START and counts every cycle in WAIT. When it reaches TIMEOUT_CYC-1 without aes_done: err<=1, -> IDLE, result_valid stays 0.
- Undefined: no counter; WAIT waits indefinitely.

Decomposition:
- Shared package: key-size encodings (KS_128=0, KS_192=1, KS_256=2, KS_BAD=3), FSM state enum, buffer index constants (BLK_BASE=0, KEY_BASE=4, LAST_IDX=11).
- One natural sub-module, aes_buf_regfile: the 12x32 storage with write port, wr_ptr/wrap logic and flattened block/key outputs. aes_buf_seq holds the FSM, handshake, result register and watchdog.

Test Plan:
- Reset then write 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF with load_temp+plus1 pairs -> aes_block=0xCCDDEEFF8899AABB4455667700112233, wr_ptr=4.
- aes_w key_size_in=2, 8 key writes, enable_aes; model returns 0x...DEADBEEF after 11 cycles -> one aes_start pulse, aes_key_size=2, result_valid=1, rd_sel=0 gives 0xDEADBEEF.
- 13 plus1 pulses from reset -> wr_ptr wraps to 1; a load_temp then writes buf[1].
- load_temp asserted during WAIT with wdata=0xFFFFFFFF -> stall=1, buffer unchanged until aes_done; after return to IDLE the held write lands.
- aes_w key_size_in=3, enable_aes -> err=1, no aes_start, state stays IDLE.
- With AES_BUF_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16, never assert aes_done -> IDLE reached 16 cycles after START, err=1, result_valid=0.
